// File: rtl/trackball_pkg.sv
// Shared types for the horizontal trackball filter: FSM state encoding and direction levels.
package trackball_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM_R = 3'd1,
    ARM_L = 3'd2,
    RUN_R = 3'd3,
    RUN_L = 3'd4
  } tb_state_e;

  localparam logic TB_DIR_R = 1'b1;
  localparam logic TB_DIR_L = 1'b0;

endpackage

// File: rtl/trackball_pos_acc.sv
// Signed up/down position accumulator with synchronous clear.
// Build option TRACKBALL_POS_SAT_EN: saturate at the signed limits instead of wrapping.
module trackball_pos_acc #(
  parameter int POS_W = 8
) (
  input  logic                    horclk,
  input  logic                    rstclr_l,
  input  logic                    clr,
  input  logic                    step_en,
  input  logic                    step_up,
  output logic signed [POS_W-1:0] pos,
  output logic                    step_ok
);

  localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

`ifdef TRACKBALL_POS_SAT_EN
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  // A step into the limit is swallowed so the CPU sees no phantom event.
  assign step_ok = step_en && (step_up ? (pos != POS_MAX) : (pos != POS_MIN));
`else
  assign step_ok = step_en;
`endif

  always_ff @(posedge horclk or negedge rstclr_l) begin
    if (!rstclr_l) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (step_ok) begin
      pos <= step_up ? (pos + POS_ONE) : (pos - POS_ONE);
    end
  end

endmodule

// File: rtl/trackball_hfilter.sv
// Horizontal trackball motion filter: hysteresis on raw steps, accepted steps drive position and a step toggle.
// Position saturation is enabled by defining TRACKBALL_POS_SAT_EN.
//
// state | meaning
// IDLE  | no direction history; next step starts arming
// ARM_R | counting consecutive right steps toward HYST
// ARM_L | counting consecutive left steps toward HYST
// RUN_R | locked right; each right step is accepted
// RUN_L | locked left; each left step is accepted
module trackball_hfilter
  import trackball_pkg::*;
#(
  parameter int HYST  = 3,
  parameter int POS_W = 8
) (
  input  logic                    horclk,
  input  logic                    rstclr_l,
  input  logic                    dir_in,
  input  logic                    steerclr,
  output logic                    fdir,
  output logic                    locked,
  output logic                    fstep_tgl,
  output logic signed [POS_W-1:0] pos,
  output logic [3:0]              rev_cnt
);

  tb_state_e  state, state_nx, arm_d, run_d;
  logic [3:0] run, run_nx;
  logic [4:0] run_inc;
  logic       dir_r, fdir_nx, accept, rev_inc, step_ok;

  assign dir_r   = (dir_in == TB_DIR_R);
  assign arm_d   = dir_r ? ARM_R : ARM_L;
  assign run_d   = dir_r ? RUN_R : RUN_L;
  assign run_inc = {1'b0, run} + 5'd1;

  always_comb begin
    state_nx = state;
    run_nx   = run;
    fdir_nx  = fdir;
    accept   = 1'b0;
    rev_inc  = 1'b0;
    case (state)
      IDLE: begin
        run_nx = 4'd1;
        if (HYST == 1) begin
          state_nx = run_d;
          fdir_nx  = dir_in;
          accept   = 1'b1;
        end else begin
          state_nx = arm_d;
        end
      end
      ARM_R, ARM_L: begin
        if ((state == ARM_R) == dir_r) begin
          run_nx = run_inc[3:0];
          if (run_inc >= 5'(HYST)) begin
            state_nx = run_d;
            fdir_nx  = dir_in;
            accept   = 1'b1;
          end
        end else begin
          state_nx = arm_d;
          run_nx   = 4'd1;
        end
      end
      RUN_R, RUN_L: begin
        if ((state == RUN_R) == dir_r) begin
          accept = 1'b1;
        end else begin
          // fdir is held until the opposite direction is fully re-acquired
          state_nx = arm_d;
          run_nx   = 4'd1;
          rev_inc  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge horclk or negedge rstclr_l) begin
    if (!rstclr_l) begin
      state     <= IDLE;
      run       <= 4'd0;
      fdir      <= 1'b0;
      locked    <= 1'b0;
      fstep_tgl <= 1'b0;
      rev_cnt   <= 4'd0;
    end else if (steerclr) begin
      state   <= IDLE;
      run     <= 4'd0;
      locked  <= 1'b0;
      rev_cnt <= 4'd0;
    end else begin
      state  <= state_nx;
      run    <= run_nx;
      fdir   <= fdir_nx;
      locked <= (state_nx == RUN_R) || (state_nx == RUN_L);
      if (step_ok) fstep_tgl <= ~fstep_tgl;
      if (rev_inc && (rev_cnt != 4'hF)) rev_cnt <= rev_cnt + 4'd1;
    end
  end

  trackball_pos_acc #(.POS_W(POS_W)) u_pos_acc (
    .horclk   (horclk),
    .rstclr_l (rstclr_l),
    .clr      (steerclr),
    .step_en  (accept & ~steerclr),
    .step_up  (dir_in),
    .pos      (pos),
    .step_ok  (step_ok)
  );

endmodule

// File: tb/tb_trackball_hfilter.sv
// Scoreboard bench for trackball_hfilter (HYST=3, POS_W=8); expectations follow TRACKBALL_POS_SAT_EN when defined.
module tb_trackball_hfilter;

  logic              horclk = 1'b0;
  logic              rstclr_l = 1'b1;
  logic              dir_in = 1'b0;
  logic              steerclr = 1'b0;
  logic              fdir, locked, fstep_tgl;
  logic signed [7:0] pos;
  logic [3:0]        rev_cnt;

  typedef struct {
    logic              fdir;
    logic              locked;
    logic              tgl;
    logic signed [7:0] pos;
    logic [3:0]        rev;
    string             name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  trackball_hfilter #(.HYST(3), .POS_W(8)) dut (
    .horclk    (horclk),
    .rstclr_l  (rstclr_l),
    .dir_in    (dir_in),
    .steerclr  (steerclr),
    .fdir      (fdir),
    .locked    (locked),
    .fstep_tgl (fstep_tgl),
    .pos       (pos),
    .rev_cnt   (rev_cnt)
  );

  task automatic push(input string nm, input logic fd, input logic lk, input logic tg,
                      input int p, input int rv);
    exp_t e;
    e.fdir = fd; e.locked = lk; e.tgl = tg; e.pos = 8'(p); e.rev = 4'(rv); e.name = nm;
    exp_q.push_back(e);
  endtask

  // One raw step: drive inputs, then one horclk pulse.
  task automatic step(input logic d, input logic clr, input string nm, input logic fd,
                      input logic lk, input logic tg, input int p, input int rv);
    dir_in = d;
    steerclr = clr;
    push(nm, fd, lk, tg, p, rv);
    #5 horclk = 1'b1;
    #5 horclk = 1'b0;
    steerclr = 1'b0;
  endtask

  task automatic pulse_reset(input string nm);
    push(nm, 1'b0, 1'b0, 1'b0, 0, 0);
    #2 rstclr_l = 1'b0;
    #3 rstclr_l = 1'b1;
    #2;
  endtask

  // Monitor: outputs change only on a horclk edge or async reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge horclk or negedge rstclr_l);
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: no expectation queued, got pos=%0d tgl=%b", pos, fstep_tgl);
      end else begin
        e = exp_q.pop_front();
        if ({fdir, locked, fstep_tgl, pos, rev_cnt} !== {e.fdir, e.locked, e.tgl, e.pos, e.rev}) begin
          n_err++;
          $display("FAIL %s: got fdir=%b locked=%b tgl=%b pos=%0d rev=%0d, expected fdir=%b locked=%b tgl=%b pos=%0d rev=%0d",
                   e.name, fdir, locked, fstep_tgl, pos, rev_cnt,
                   e.fdir, e.locked, e.tgl, e.pos, e.rev);
        end
      end
    end
  end

  initial begin
    logic fd, tg, nd;
    int   p, rv;

    pulse_reset("reset_init");

    // Acquire right after three steps
    step(1, 0, "acq_r1", 0, 0, 0, 0, 0);
    step(1, 0, "acq_r2", 0, 0, 0, 0, 0);
    step(1, 0, "acq_r3", 1, 1, 1, 1, 0);

    // Reversal while arming: no accept, no rev count
    pulse_reset("reset_mid_run_r");
    step(1, 0, "arm_r1", 0, 0, 0, 0, 0);
    step(1, 0, "arm_r2", 0, 0, 0, 0, 0);
    step(0, 0, "arm_l1", 0, 0, 0, 0, 0);
    step(0, 0, "arm_l2", 0, 0, 0, 0, 0);
    step(0, 0, "run_l", 0, 1, 1, -1, 0);

    // Async reset between edges while in RUN_L
    pulse_reset("reset_mid_run_l");

    // Jitter reversal in RUN_R then re-acquire
    step(1, 0, "jit_r1", 0, 0, 0, 0, 0);
    step(1, 0, "jit_r2", 0, 0, 0, 0, 0);
    step(1, 0, "jit_r3", 1, 1, 1, 1, 0);
    step(0, 0, "jit_l", 1, 0, 1, 1, 1);
    step(1, 0, "jit_rearm1", 1, 0, 1, 1, 1);
    step(1, 0, "jit_rearm2", 1, 0, 1, 1, 1);
    step(1, 0, "jit_reacq", 1, 1, 0, 2, 1);

    // Climb to 5, then steerclr on a right step
    step(1, 0, "climb3", 1, 1, 1, 3, 1);
    step(1, 0, "climb4", 1, 1, 0, 4, 1);
    step(1, 0, "climb5", 1, 1, 1, 5, 1);
    step(1, 1, "steerclr", 1, 0, 1, 0, 0);
    step(1, 0, "clr_arm1", 1, 0, 1, 0, 0);
    step(1, 0, "clr_arm2", 1, 0, 1, 0, 0);
    step(1, 0, "clr_reacq", 1, 1, 0, 1, 0);

    // Repeated full reversals: rev_cnt saturates at 15
    fd = 1'b1; tg = 1'b0; p = 1; rv = 0;
    for (int k = 0; k < 16; k++) begin
      nd = ~fd;
      rv = (rv < 15) ? rv + 1 : 15;
      step(nd, 0, "rev_arm1", fd, 0, tg, p, rv);
      step(nd, 0, "rev_arm2", fd, 0, tg, p, rv);
      fd = nd;
      tg = ~tg;
      p  = nd ? p + 1 : p - 1;
      step(nd, 0, "rev_run", fd, 1, tg, p, rv);
    end

    // Position limit at +127
    pulse_reset("reset_before_wrap");
    step(1, 0, "wrap_arm1", 0, 0, 0, 0, 0);
    step(1, 0, "wrap_arm2", 0, 0, 0, 0, 0);
    for (int i = 1; i <= 127; i++) begin
      step(1, 0, "wrap_climb", 1, 1, logic'(i % 2), i, 0);
    end
`ifdef TRACKBALL_POS_SAT_EN
    step(1, 0, "limit_step", 1, 1, 1, 127, 0);
    step(0, 0, "limit_rev", 1, 0, 1, 127, 1);
`else
    step(1, 0, "limit_step", 1, 1, 0, -128, 0);
    step(0, 0, "limit_rev", 1, 0, 0, -128, 1);
`endif

    #10;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
